stream_xcrypt: RTL and testbench
================================

Name: stream_xcrypt

Overview:
- Parametrised, handshaked XOR stream-cipher datapath; successor to the fixed 7-bit decrypt stage.
- Sits between the keystream generator (rc4 core) and the text datapath. Encryption and decryption are the same operation.
- Buffers keystream words in a small FIFO and discards the first DROP keystream words (RC4-drop).
- Uses valid/ready flow control on all three streams, with bypass and session start/clear control.

Parameters:
- W, 8: data and keystream word width in bits.
- DEPTH, 4: keystream FIFO depth in words; power of 2, at least 2.
- DROP, 3: number of initial keystream words discarded per session; 0 is legal.
- CNT_W, 16: width of the processed-word counter.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous, active-low reset.
- start, input, 1: one-cycle pulse that begins a session.
- clear, input, 1: synchronous abort; flushes the FIFO and returns to IDLE.
- bypass, input, 1: when 1, data passes through unmodified and no keystream is consumed.
- ks_init_done, input, 1: keystream generator has finished key scheduling.
- ks_data, input, W: keystream word.
- ks_valid, input, 1: ks_data is valid.
- ks_ready, output, 1: block accepts ks_data this cycle.
- in_data, input, W: plaintext or ciphertext word.
- in_valid, input, 1: in_data is valid.
- in_ready, output, 1: block accepts in_data this cycle.
- out_data, output, W: in_data XOR keystream word.
- out_valid, output, 1: out_data is valid.
- out_ready, input, 1: downstream accepts out_data.
- busy, output, 1: state is not IDLE.
- ks_level, output, $clog2(DEPTH+1): current FIFO occupancy.
- word_count, output, CNT_W: words emitted in this session.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, FIFO empty, drop counter=0, word_count=0.
  - out_valid=0, out_data=0, ks_ready=0, in_ready=0, busy=0, ks_level=0.
- States: IDLE, WAIT_INIT, DROP, RUN.
- IDLE:
  - All readies are 0.
  - start=1 -> WAIT_INIT. This also clears word_count and loads the drop counter with DROP.
- WAIT_INIT:
  - Readies are 0.
  - ks_init_done=1 -> DROP if DROP>0, otherwise RUN.
- DROP:
  - ks_ready=1. Each ks_valid&ks_ready handshake decrements the drop counter and the word is discarded, not written to the FIFO.
  - The cycle the counter reaches 0 -> RUN.
  - in_ready=0 throughout.
- RUN, keystream side:
  - ks_ready = FIFO not full.
  - ks_ready is registered from occupancy; it has no combinational path from out_ready or in_valid.
- RUN, data side:
  - in_ready = (bypass | FIFO not empty) & (!out_valid | out_ready).
  - On in_valid&in_ready: next cycle out_valid=1 and out_data = in_data ^ FIFO head (or in_data if bypass). The FIFO pops unless bypass.
  - Latency is exactly 1 cycle from input handshake to out_valid.
- Output register:
  - While out_valid&!out_ready, out_data and out_valid hold stable.
  - out_valid drops after an out_ready handshake if no new input was accepted that cycle.
  - Back-to-back throughput is 1 word/cycle when FIFO is non-empty and out_ready=1.
- FIFO:
  - Push and pop in the same cycle are allowed at any occupancy, including full (pop frees the slot; ks_ready was already computed from pre-cycle full, so no overflow) and empty (no pop possible, since in_ready=0 unless bypass).
  - Pointers wrap modulo DEPTH. ks_level = pushes - pops, range 0..DEPTH.
- word_count:
  - Increments on each out_valid&out_ready handshake.
  - Saturates at all-ones (no wrap).
- clear=1, any state:
  - Next cycle: state=IDLE, FIFO flushed, ks_level=0, out_valid=0, drop counter=0.
  - word_count is retained until the next start.
  - clear has priority over start and over all handshakes in the same cycle.
- start while not IDLE: ignored.
- Toggling bypass mid-stream: takes effect on the next input handshake. FIFO contents are preserved, so the keystream alignment is not skipped.
- The output is bitwise XOR, W bits, with no carry.
- Asserting rst mid-operation returns everything to reset values immediately.

Test Plan:
- Reset, then start, then ks_init_done=1; feed keystream 0x11,0x22,0x33,0xA5,0x5A with DROP=3, then in_data 0x48,0x69 -> DROP accepts 3 words; out_data 0xED then 0x33; word_count=2.
- DROP=0, DEPTH=4; fill FIFO with 4 keystream words while in_valid=0 -> ks_level=4, ks_ready=0. Then stream 4 inputs with out_ready=1 -> 4 outputs on consecutive cycles, 1-cycle latency.
- Hold out_ready=0 with one output pending -> out_data stable, in_ready=0, no FIFO pop. Release out_ready -> resumes with no loss or duplication.
- bypass=1, in_data 0x7F -> out_data 0x7F, ks_level unchanged. Deassert bypass -> the next word uses the preserved FIFO head.
- Pulse clear mid-RUN with ks_level=3 and out_valid=1 -> next cycle IDLE, ks_level=0, out_valid=0, busy=0. A following start re-drops DROP words.
- Drive rst=0 asynchronously between clock edges during RUN -> all outputs reset immediately. A concurrent start or clear with reset is ignored; both must be reasserted after release.

Source files
------------

// File: rtl/stream_xcrypt.sv
// XOR stream-cipher datapath with keystream FIFO and RC4-drop.
// Encrypt and decrypt are the same operation; all streams use valid/ready.
module stream_xcrypt #(
    parameter int W = 8,
    parameter int DEPTH = 4,
    parameter int DROP = 3,
    parameter int CNT_W = 16,
    localparam int LW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clear,
    input  logic             bypass,
    input  logic             ks_init_done,
    input  logic [W-1:0]     ks_data,
    input  logic             ks_valid,
    output logic             ks_ready,
    input  logic [W-1:0]     in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [W-1:0]     out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic [LW-1:0]    ks_level,
    output logic [CNT_W-1:0] word_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = $clog2(DROP + 2);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;
    localparam logic [1:0] S_RUN  = 2'd3;

    logic [1:0]    state;
    logic [DW-1:0] drop_cnt;
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level;

    logic full;
    logic empty;
    logic ks_fire;
    logic drop_fire;
    logic push;
    logic in_fire;
    logic pop;
    logic out_fire;
    logic start_ok;

    assign full      = level == LW'(DEPTH);
    assign empty     = level == '0;
    assign busy      = state != S_IDLE;
    assign ks_level  = level;

    // ks_ready depends only on registered state and occupancy
    assign ks_ready  = (state == S_DROP) || ((state == S_RUN) && !full);
    assign in_ready  = (state == S_RUN) && (bypass || !empty)
                       && (!out_valid || out_ready);

    assign ks_fire   = ks_valid && ks_ready && !clear;
    assign drop_fire = ks_fire && (state == S_DROP);
    assign push      = ks_fire && (state == S_RUN);
    assign in_fire   = in_valid && in_ready && !clear;
    assign pop       = in_fire && !bypass;
    assign out_fire  = out_valid && out_ready && !clear;
    assign start_ok  = start && !clear && (state == S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            drop_cnt <= '0;
        end else if (clear) begin
            state    <= S_IDLE;
            drop_cnt <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_WAIT;
                        drop_cnt <= DW'(DROP);
                    end
                end
                S_WAIT: begin
                    if (ks_init_done)
                        state <= (DROP > 0) ? S_DROP : S_RUN;
                end
                S_DROP: begin
                    if (drop_fire) begin
                        drop_cnt <= drop_cnt - DW'(1);
                        if (drop_cnt == DW'(1))
                            state <= S_RUN;
                    end
                end
                default: begin
                    state <= S_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= ks_data;
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            level <= level + LW'(push) - LW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (clear) begin
            out_valid <= 1'b0;
        end else if (in_fire) begin
            out_valid <= 1'b1;
            out_data  <= bypass ? in_data : (in_data ^ mem[rd_ptr]);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_count <= '0;
        end else if (start_ok) begin
            word_count <= '0;
        end else if (out_fire && (word_count != '1)) begin
            word_count <= word_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_stream_xcrypt.sv
// Randomised scoreboard bench for stream_xcrypt.
// Queue-based keystream/drop model with directed boundary scenarios.
module tb_stream_xcrypt;

    localparam int W = 8;
    localparam int DEPTH = 4;
    localparam int DROP = 3;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             clear = 1'b0;
    logic             bypass = 1'b0;
    logic             ks_init_done = 1'b0;
    logic [W-1:0]     ks_data = '0;
    logic             ks_valid = 1'b0;
    logic             ks_ready;
    logic [W-1:0]     in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     out_data;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             busy;
    logic [2:0]       ks_level;
    logic [CNT_W-1:0] word_count;

    int checks = 0;
    int failures = 0;

    stream_xcrypt #(.W(W), .DEPTH(DEPTH), .DROP(DROP), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .clear(clear),
        .bypass(bypass), .ks_init_done(ks_init_done),
        .ks_data(ks_data), .ks_valid(ks_valid), .ks_ready(ks_ready),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .ks_level(ks_level), .word_count(word_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    // reference model state
    logic [W-1:0] ks_q [$];
    logic [W-1:0] exp_q [$];
    logic [W-1:0] seen [$];
    int phase = 0;
    int sess_ks = 0;
    int wc = 0;
    bit prev_stall = 0;
    logic [W-1:0] prev_data = '0;

    // stimulus side: keystream model and expected-response generation
    always @(negedge clk) begin
        if (!rst) begin
            phase = 0;
            sess_ks = 0;
            ks_q.delete();
        end else begin
            bit run;
            chk("busy", busy, phase != 0);
            chk("ks_level", ks_level, ks_q.size());
            chk("ks_ready", ks_ready,
                phase == 2 && (sess_ks < DROP || ks_q.size() < DEPTH));
            run = phase == 2 && sess_ks >= DROP;
            chk("in_ready", in_ready,
                run && (bypass || ks_q.size() > 0) && (!out_valid || out_ready));
            if (clear) begin
                phase = 0;
                ks_q.delete();
            end else begin
                if (in_valid && in_ready) begin
                    if (bypass)
                        exp_q.push_back(in_data);
                    else if (ks_q.size() > 0)
                        exp_q.push_back(in_data ^ ks_q.pop_front());
                end
                if (ks_valid && ks_ready) begin
                    if (sess_ks < DROP) sess_ks++;
                    else ks_q.push_back(ks_data);
                end
                if (phase == 0 && start) begin
                    phase = 1;
                    sess_ks = 0;
                end else if (phase == 1 && ks_init_done) begin
                    phase = 2;
                end
            end
        end
    end

    // monitor side: pops the scoreboard on each output handshake
    always @(negedge clk) begin
        if (!rst) begin
            wc = 0;
            prev_stall = 0;
            exp_q.delete();
        end else begin
            chk("word_count", word_count, wc);
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, prev_data);
            end
            if (clear) begin
                exp_q.delete();
                prev_stall = 0;
            end else begin
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0)
                        chk("unexpected_out", out_data, 32'hFFFF_FFFF);
                    else
                        chk("out_data", out_data, exp_q.pop_front());
                    seen.push_back(out_data);
                    if (wc < 65535) wc++;
                end
                prev_stall = out_valid && !out_ready;
                prev_data = out_data;
                if (start && !busy) wc = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_ks(input logic [W-1:0] d);
        int n = 0;
        ks_data = d;
        ks_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
            if (!ks_ready) tick();
        end while (!ks_ready && n < 50);
        if (n >= 50) chk("ks_timeout", n, 0);
        tick();
        ks_valid = 1'b0;
    endtask

    task automatic send_in(input logic [W-1:0] d);
        int n = 0;
        in_data = d;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
            if (!in_ready) tick();
        end while (!in_ready && n < 50);
        if (n >= 50) chk("in_timeout", n, 0);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic last_seen(input string nm, input logic [W-1:0] e);
        if (seen.size() == 0) chk(nm, 32'hDEAD, e);
        else chk(nm, seen[seen.size()-1], e);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_ks_ready", ks_ready, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_level", ks_level, 0);
        chk("rst_wc", word_count, 0);
        tick();
        rst = 1'b1;
        ks_init_done = 1'b1;

        // session with RC4-drop of three words
        start = 1'b1;
        tick();
        start = 1'b0;
        send_ks(8'h11); send_ks(8'h22); send_ks(8'h33);
        send_ks(8'hA5); send_ks(8'h5A);
        @(negedge clk);
        chk("drop_level", ks_level, 2);
        tick();
        out_ready = 1'b1;
        seen.delete();
        send_in(8'h48);
        send_in(8'h69);
        repeat (3) tick();
        @(negedge clk);
        chk("t1_word0", seen.size() > 0 ? seen[0] : 8'h00, 8'hED);
        chk("t1_word1", seen.size() > 1 ? seen[1] : 8'h00, 8'h33);
        chk("t1_count", word_count, 2);
        tick();

        // fill FIFO then stream back to back
        send_ks(8'hA1); send_ks(8'hB2); send_ks(8'hC3); send_ks(8'hD4);
        @(negedge clk);
        chk("full_level", ks_level, 4);
        chk("full_ks_ready", ks_ready, 0);
        tick();
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data = W'(k + 1);
            @(negedge clk);
            chk("b2b_in_ready", in_ready, 1);
            if (k > 0) chk("b2b_out_valid", out_valid, 1);
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_last_valid", out_valid, 1);
        tick();
        @(negedge clk);
        chk("b2b_idle_valid", out_valid, 0);
        chk("b2b_level", ks_level, 0);
        tick();

        // back-pressure
        send_ks(8'hE1); send_ks(8'hE2);
        out_ready = 1'b0;
        send_in(8'h10);
        in_valid = 1'b1;
        in_data = 8'h20;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_valid", out_valid, 1);
            chk("bp_data", out_data, 8'hF1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_level", ks_level, 1);
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_resume", in_ready, 1);
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        last_seen("bp_second", 8'hC2);

        // bypass keeps keystream alignment
        send_ks(8'h3C);
        bypass = 1'b1;
        send_in(8'h7F);
        bypass = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        chk("byp_level", ks_level, 1);
        last_seen("byp_data", 8'h7F);
        tick();
        send_in(8'h0F);
        repeat (2) tick();
        last_seen("byp_after", 8'h33);

        // clear mid-run
        send_ks(8'h01); send_ks(8'h02); send_ks(8'h03); send_ks(8'h04);
        out_ready = 1'b0;
        send_in(8'h55);
        @(negedge clk);
        chk("pre_clr_level", ks_level, 3);
        chk("pre_clr_valid", out_valid, 1);
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        @(negedge clk);
        chk("clr_level", ks_level, 0);
        chk("clr_valid", out_valid, 0);
        chk("clr_busy", busy, 0);
        chk("clr_count", word_count, 10);
        tick();
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        send_ks(8'h91); send_ks(8'h92); send_ks(8'h93);
        @(negedge clk);
        chk("redrop_level", ks_level, 0);
        chk("restart_count", word_count, 0);
        tick();
        send_ks(8'h94);
        @(negedge clk);
        chk("redrop_kept", ks_level, 1);
        tick();

        // asynchronous reset between edges
        #1;
        rst = 1'b0;
        start = 1'b1;
        clear = 1'b1;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_data", out_data, 0);
        chk("arst_ks_ready", ks_ready, 0);
        chk("arst_in_ready", in_ready, 0);
        chk("arst_busy", busy, 0);
        chk("arst_level", ks_level, 0);
        chk("arst_wc", word_count, 0);
        repeat (2) tick();
        rst = 1'b1;
        start = 1'b0;
        clear = 1'b0;
        @(negedge clk);
        chk("arst_post_busy", busy, 0);
        tick();
        @(negedge clk);
        chk("arst_post_busy2", busy, 0);
        tick();

        // randomised traffic
        for (int c = 0; c < 3000; c++) begin
            start = ($urandom_range(15) == 0);
            clear = ($urandom_range(127) == 0);
            ks_init_done = ($urandom_range(3) != 0);
            ks_valid = $urandom_range(1);
            ks_data = W'($urandom);
            in_valid = ($urandom_range(2) != 0);
            in_data = W'($urandom);
            out_ready = ($urandom_range(3) != 0);
            bypass = ($urandom_range(7) == 0);
            tick();
        end
        start = 1'b0;
        clear = 1'b0;
        ks_valid = 1'b0;
        in_valid = 1'b0;
        bypass = 1'b0;
        out_ready = 1'b1;
        repeat (5) tick();
        @(negedge clk);
        chk("drain_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
